// File: rtl/clks_alot_p.sv
// Shared types for the clock-pause scheduler: FSM state encoding, the latched
// request record and the width of the rate/duration counters.
package clks_alot_p;

  localparam int RATE_COUNTER_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    HOLD    = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } pause_sched_state_e;

  typedef struct packed {
    logic                          polarity;
    logic [RATE_COUNTER_WIDTH-1:0] cycles;
  } pause_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the search starts at i_ptr and wraps,
// returning the first requesting index as both a one-hot vector and a number.
module rr_arbiter #(
  parameter int REQ_N = 4,
  parameter int IDX_W = 2
) (
  input  logic [REQ_N-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [REQ_N-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(REQ_N);

  logic [REQ_N-1:0] w_rot;
  logic [IDX_W:0]   w_sum;
  logic             w_found;

  // Bit j of the rotated vector is requester (ptr + j) mod REQ_N.
  assign w_rot = REQ_N'({i_req, i_req} >> i_ptr);

  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, i_ptr} + (IDX_W+1)'(i);
      end
    end
    if (w_sum >= N_L) begin
      w_sum = w_sum - N_L;
    end
  end

  assign o_valid = w_found;
  assign o_idx   = w_sum[IDX_W-1:0];
  assign o_grant = w_found ? (REQ_N'(1) << w_sum[IDX_W-1:0]) : '0;

endmodule

// File: rtl/pause_scheduler.sv
// Arbitrates clock-pause requests from several requesters and sequences one
// pause at a time through the pausable clock generator handshake.
module pause_scheduler
  import clks_alot_p::*;
#(
  parameter int REQUESTER_COUNT = 4,
  parameter int ARM_TIMEOUT     = 255
) (
  input  logic                                          clk,
  input  logic                                          sync_rst_n,
  input  logic                                          clk_en,
  input  logic [REQUESTER_COUNT-1:0]                    req_valid_i,
  input  logic [REQUESTER_COUNT-1:0]                    req_polarity_i,
  input  logic [REQUESTER_COUNT*RATE_COUNTER_WIDTH-1:0] req_cycles_i,
  input  logic                                          abort_i,
  input  logic                                          pause_active_i,
  input  logic [RATE_COUNTER_WIDTH-1:0]                 pause_duration_i,
  output logic                                          pause_en_o,
  output logic                                          pause_polarity_o,
  output logic [REQUESTER_COUNT-1:0]                    grant_o,
  output logic [REQUESTER_COUNT-1:0]                    done_o,
  output logic [REQUESTER_COUNT-1:0]                    timeout_o,
  output logic                                          busy_o
);

  localparam int IDX_W = (REQUESTER_COUNT > 1) ? $clog2(REQUESTER_COUNT) : 1;
  localparam int TMO_W = $clog2(ARM_TIMEOUT + 1);
  localparam int RCW   = RATE_COUNTER_WIDTH;

  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(ARM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ARM_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REQUESTER_COUNT - 1);

  pause_sched_state_e         r_state;
  logic [IDX_W-1:0]           r_ptr;
  logic [IDX_W-1:0]           r_idx;
  pause_req_t                 r_req;
  logic [TMO_W-1:0]           r_tmo_cnt;
  logic                       r_timed_out;
  logic [REQUESTER_COUNT-1:0] r_done;
  logic [REQUESTER_COUNT-1:0] r_timeout;

  logic [REQUESTER_COUNT-1:0] w_arb_grant;
  logic [IDX_W-1:0]           w_arb_idx;
  logic                       w_arb_valid;
  pause_req_t                 w_sel;
  logic [REQUESTER_COUNT-1:0] w_idx_onehot;
  logic [IDX_W-1:0]           w_ptr_next;

  rr_arbiter #(
    .REQ_N (REQUESTER_COUNT),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req   (req_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  always_comb begin
    w_sel.polarity = |(req_polarity_i & w_arb_grant);
    w_sel.cycles   = '0;
    for (int i = 0; i < REQUESTER_COUNT; i++) begin
      w_sel.cycles = w_sel.cycles | ({RCW{w_arb_grant[i]}} & req_cycles_i[i*RCW +: RCW]);
    end
  end

  assign w_idx_onehot = REQUESTER_COUNT'(1) << r_idx;
  assign w_ptr_next   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);

  // done/timeout are single clk-cycle pulses: cleared every edge, set only on
  // enabled transitions.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_req       <= '0;
      r_tmo_cnt   <= '0;
      r_timed_out <= 1'b0;
      r_done      <= '0;
      r_timeout   <= '0;
    end else begin
      r_done    <= '0;
      r_timeout <= '0;
      if (clk_en) begin
        case (r_state)
          IDLE: begin
            if (w_arb_valid) begin
              r_idx       <= w_arb_idx;
              r_req       <= w_sel;
              r_tmo_cnt   <= '0;
              r_timed_out <= 1'b0;
              r_state     <= (w_sel.cycles == '0) ? DONE : ARM;
            end
          end
          ARM: begin
            if (abort_i) begin
              r_state <= RELEASE;
            end else if (pause_active_i) begin
              r_state <= HOLD;
            end else if (r_tmo_cnt == TMO_LAST) begin
              r_tmo_cnt   <= TMO_MAX;
              r_timeout   <= w_idx_onehot;
              r_timed_out <= 1'b1;
              r_state     <= RELEASE;
            end else if (r_tmo_cnt != TMO_MAX) begin
              r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
          end
          HOLD: begin
            if (abort_i || (pause_duration_i >= r_req.cycles)) begin
              r_state <= RELEASE;
            end
          end
          RELEASE: begin
            if (!pause_active_i) begin
              r_state <= DONE;
            end
          end
          DONE: begin
            // A timed-out request is retired silently; its timeout pulse was the report.
            if (!r_timed_out) begin
              r_done <= w_idx_onehot;
            end
            r_ptr   <= w_ptr_next;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o           = (r_state != IDLE);
  assign pause_en_o       = (r_state == ARM) || (r_state == HOLD);
  assign pause_polarity_o = r_req.polarity;
  assign grant_o          = busy_o ? w_idx_onehot : '0;
  assign done_o           = r_done;
  assign timeout_o        = r_timeout;

endmodule

// File: doc/pause_scheduler.md
PAUSE_SCHEDULER -- requirements
Module: pause_scheduler

Interface
REQ-001 Parameter REQUESTER_COUNT, default 4; number of independent pause requesters (2..8).
REQ-002 Parameter ARM_TIMEOUT, default 255; clk_en-qualified cycles allowed between pause_en_o rise and pause_active_i rise.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 sync_rst_n  input  1  synchronous, active-low reset.
REQ-005 clk_en  input  1  clock enable; state advances only when high.
REQ-006 req_valid_i  input  REQUESTER_COUNT  per-requester pause request level.
REQ-007 req_polarity_i  input  REQUESTER_COUNT  requested held clock level per requester.
REQ-008 req_cycles_i  input  REQUESTER_COUNT x clks_alot_p::RATE_COUNTER_WIDTH  requested pause length, in generated-clock periods.
REQ-009 abort_i  input  1  terminate the active pause early.
REQ-010 pause_active_i, pause_duration_i  input  1, RATE_COUNTER_WIDTH  pause status from the pausable clock generator.
REQ-011 pause_en_o, pause_polarity_o  output  1, 1  drive to the pausable clock generator.
REQ-012 grant_o, done_o, timeout_o  output  REQUESTER_COUNT each  one-hot grant level; one-cycle done pulse; one-cycle timeout pulse.
REQ-013 busy_o  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, ARM, HOLD, RELEASE, DONE; transitions occur only on cycles with clk_en high.
REQ-015 IDLE: if any req_valid_i bit is set, select a requester round-robin, starting after the last granted index; go to ARM, or to DONE if the latched cycles value is 0.
REQ-016 On grant, latch the index, polarity and cycles; later changes to req_* for that requester are ignored until done_o.
REQ-017 grant_o[idx] is high from the grant cycle through DONE; at most one bit is high at any time.
REQ-018 ARM: pause_en_o=1 and pause_polarity_o=latched polarity; go to HOLD when pause_active_i=1.
REQ-019 ARM: after ARM_TIMEOUT cycles without pause_active_i, pulse timeout_o[idx] and go to RELEASE.
REQ-020 HOLD: pause_en_o=1; go to RELEASE when pause_duration_i >= latched cycles.
REQ-021 abort_i in ARM or HOLD forces RELEASE on the next enabled cycle; abort_i in other states is ignored.
REQ-022 RELEASE: pause_en_o=0; go to DONE when pause_active_i=0.
REQ-023 DONE: pulse done_o[idx] for exactly one cycle, advance the round-robin pointer, and return to IDLE; no new grant is issued in the same cycle.
REQ-024 pause_polarity_o holds its last latched value outside ARM and HOLD.
REQ-025 If the granted requester drops req_valid_i mid-pause, the sequence still completes and done_o still pulses.
REQ-026 A zero-cycle request never asserts pause_en_o; done_o pulses 2 enabled cycles after the grant.
REQ-027 Comparisons are unsigned, full RATE_COUNTER_WIDTH; the timeout counter saturates at ARM_TIMEOUT and clears on entry to ARM.

Reset
REQ-028 sync_rst_n=0 on a rising edge forces IDLE, the round-robin pointer to 0, and all latched fields and counters to 0, regardless of clk_en.
REQ-029 Output values under reset: pause_en_o=0, pause_polarity_o=0, grant_o=0, done_o=0, timeout_o=0, busy_o=0.
REQ-030 Reset asserted mid-pause drops pause_en_o on the next cycle; no done_o pulse is issued for the interrupted request.

Structure
REQ-031 The FSM state enum (pause_sched_state_e) and a request struct (polarity, cycles) are placed in clks_alot_p; RATE_COUNTER_WIDTH is reused from the same package.
REQ-032 The round-robin selector is a sub-module, rr_arbiter (request vector and pointer in, one-hot grant and index out, combinational).

Verification
REQ-033 Single request: req 1, polarity 1, cycles 5, model pause_active_i after 2 cycles -> pause_en_o high until pause_duration_i=5, then a done_o[1] pulse; grant_o[1] held throughout.
REQ-034 Contention: req_valid_i=4'b1111 held continuously -> grants in order 0,1,2,3,0; no overlap; pause_en_o never high during DONE or IDLE.
REQ-035 Timeout: ARM_TIMEOUT=8, pause_active_i held 0 -> timeout_o[idx] pulses at ARM cycle 8; no done_o for that request.
REQ-036 Abort at HOLD with pause_duration_i=3 of 10 -> RELEASE; done_o pulses once pause_active_i falls.
REQ-037 Zero-cycle request -> pause_en_o stays 0; done_o pulses 2 cycles after grant; clk_en toggled 50% -> all transitions stretch, with no skipped states.
REQ-038 Reset asserted in HOLD -> next cycle all outputs 0 and state IDLE; after reset release, a pending req_valid_i[2] is granted first from pointer 0 (no other requests pending).
